// File: rtl/count_checker.sv
// rtl/count_checker.sv - step checker for a 3-bit binary/Gray counter
module count_checker (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic [2:0] count,
    input  logic       clr_err,
    output logic [2:0] bin_value,
    output logic       locked,
    output logic       err,
    output logic       wrap,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] prev_count;
    logic       prev_mode;
    logic [1:0] good_run;
    logic [1:0] next_good_run;

    logic [2:0] prev_index;
    logic [2:0] next_index;
    logic [2:0] expected;
    logic [2:0] cur_index;
    logic       compare;
    logic       step_err;
    logic       step_wrap;

    function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    function automatic logic [2:0] bin_to_gray(input logic [2:0] b);
        return b ^ {1'b0, b[2:1]};
    endfunction

    // The expected code follows the mode that produced the previous sample.
    assign prev_index = prev_mode ? gray_to_bin(prev_count) : prev_count;
    assign next_index = prev_index + 3'd1;
    assign expected   = prev_mode ? bin_to_gray(next_index) : next_index;
    assign cur_index  = mode ? gray_to_bin(count) : count;

    assign compare   = (state != ACQUIRE);
    assign step_err  = compare && (count != expected);
    assign step_wrap = compare && (count == expected) && (prev_index == 3'd7);
    assign locked    = (state == LOCKED);

    always_comb begin
        next_state    = state;
        next_good_run = good_run;
        case (state)
            ACQUIRE: begin
                next_state    = LOCKED;
                next_good_run = 2'd0;
            end
            LOCKED: begin
                if (step_err) begin
                    next_state    = FAULT;
                    next_good_run = 2'd0;
                end
            end
            FAULT: begin
                if (step_err) begin
                    next_good_run = 2'd0;
                end else if (good_run == 2'd3) begin
                    next_state    = LOCKED;
                    next_good_run = 2'd0;
                end else begin
                    next_good_run = good_run + 2'd1;
                end
            end
            default: begin
                next_state    = ACQUIRE;
                next_good_run = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACQUIRE;
            prev_count <= 3'd0;
            prev_mode  <= 1'b0;
            good_run   <= 2'd0;
            bin_value  <= 3'd0;
            err        <= 1'b0;
            wrap       <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            state      <= next_state;
            prev_count <= count;
            prev_mode  <= mode;
            good_run   <= next_good_run;
            bin_value  <= cur_index;
            err        <= step_err;
            wrap       <= step_wrap;
            // A clear coinciding with an error still records that error.
            if (clr_err) begin
                err_cnt <= step_err ? 8'd1 : 8'd0;
            end else if (step_err && (err_cnt != 8'hff)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule
